// File: rtl/mic1_mem_responder_if.sv
// mic1_mem_responder_if -- bundle between the Mic-1 datapath and its memory.
//
// Signals
//   mem_ctrl  [2:0]  {write, read, fetch} from the MEM field of the microinstruction
//   mar       [31:0] word address for read and write
//   mdr_out   [31:0] write data from MDR
//   pc        [31:0] byte address for fetch
//   mdr_in    [31:0] read data to MDR
//   mdr_load         MDR capture strobe
//   mbr_in    [7:0]  fetched byte to MBR
//   mbr_load         MBR capture strobe
//   fault            one-cycle pulse on an illegal or out-of-range request
//
// Handshake: there is no backpressure. A request is taken on every rising
// edge where its mem_ctrl bit is set. Each read or fetch is answered by
// exactly one single-cycle load strobe, in issue order. The data bus carries
// valid data only while its strobe is high and holds its value otherwise.
//
// Modports: master = datapath side (drives requests), slave = memory side.

interface mic1_mem_responder_if;
  logic [2:0]  mem_ctrl;
  logic [31:0] mar;
  logic [31:0] mdr_out;
  logic [31:0] pc;
  logic [31:0] mdr_in;
  logic        mdr_load;
  logic [7:0]  mbr_in;
  logic        mbr_load;
  logic        fault;

  modport master (
    output mem_ctrl, mar, mdr_out, pc,
    input  mdr_in, mdr_load, mbr_in, mbr_load, fault
  );

  modport slave (
    input  mem_ctrl, mar, mdr_out, pc,
    output mdr_in, mdr_load, mbr_in, mbr_load, fault
  );
endinterface

// File: rtl/mic1_mem_responder.sv
// mic1_mem_responder -- pipelined word memory serving the Mic-1 datapath.
//
// Writes commit at the edge that samples them. Reads return a 32-bit word to
// MDR, and fetches return a big-endian byte to MBR. Both are answered
// MEM_LATENCY edges after the sampling edge. Read and fetch run as two
// independent lanes of the same pipeline, and a new request may be issued
// every cycle.
//
// Parameters
//   ADDR_WORDS   depth of MainMemory in 32-bit words (power of two)
//   MEM_LATENCY  1 or 2 edges from request sample to strobe
//
// Ports
//   clock  rising-edge clock
//   reset  synchronous, active-high. Clears outputs and in-flight requests,
//          but does not clear MainMemory.
//   bus    mic1_mem_responder_if.slave
//
// Optional feature
//   MEM_BOUNDS_CHECK_EN  when defined, a word address at or above ADDR_WORDS
//   is suppressed: no write, data 0, strobe still produced, and fault pulsed.
//   When undefined, addresses wrap modulo ADDR_WORDS.
//
// MainMemory is not reset. It is meant to be preloaded through its
// hierarchical name.

module mic1_mem_responder #(
  parameter int ADDR_WORDS  = 1024,
  parameter int MEM_LATENCY = 1
) (
  input logic                  clock,
  input logic                  reset,
  mic1_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(ADDR_WORDS);

  // One pipeline slot. Data is captured at the sampling edge instead of an
  // address. As a result, a same-edge write stays invisible, and any write
  // from an earlier edge is already in the array when the slot is filled.
  typedef struct packed {
    logic        rd_v;
    logic [31:0] rd_data;
    logic        fe_v;
    logic [7:0]  fe_byte;
    logic        flt;
  } stage_t;

  logic [31:0] MainMemory [ADDR_WORDS];

  logic          wr;
  logic          rd;
  logic          fe;
  logic [AW-1:0] mar_idx;
  logic [AW-1:0] pc_idx;
  logic [1:0]    lane;
  logic          mar_oob;
  logic          pc_oob;
  logic [31:0]   rd_word;
  logic [31:0]   fe_word;
  logic [7:0]    fe_byte;
  stage_t        req;
  stage_t        s1;
  stage_t        last;
  logic          unused_addr_bits;

  // The upper address bits only matter when bounds checking is built in.
  assign unused_addr_bits = ^{bus.mar[31:AW], bus.pc[31:AW+2]};

  always_comb begin
    wr      = bus.mem_ctrl[2];
    rd      = bus.mem_ctrl[1];
    fe      = bus.mem_ctrl[0];
    mar_idx = bus.mar[AW-1:0];
    pc_idx  = bus.pc[AW+1:2];
    lane    = bus.pc[1:0];
`ifdef MEM_BOUNDS_CHECK_EN
    mar_oob = (bus.mar >> AW) != 32'd0;
    pc_oob  = (bus.pc >> (AW + 2)) != 32'd0;
`else
    mar_oob = 1'b0;
    pc_oob  = 1'b0;
`endif
    rd_word = mar_oob ? 32'd0 : MainMemory[mar_idx];
    fe_word = pc_oob  ? 32'd0 : MainMemory[pc_idx];

    // Big-endian lane select: lane 0 is the most significant byte.
    fe_byte = fe_word[7:0];
    case (lane)
      2'd0:    fe_byte = fe_word[31:24];
      2'd1:    fe_byte = fe_word[23:16];
      2'd2:    fe_byte = fe_word[15:8];
      default: fe_byte = fe_word[7:0];
    endcase

    req         = '0;
    // A read that shares its cycle with a write is dropped. The write wins.
    req.rd_v    = rd && !wr;
    req.rd_data = rd_word;
    req.fe_v    = fe;
    req.fe_byte = fe_byte;
    req.flt     = (wr && rd) || (mar_oob && (wr || rd)) || (pc_oob && fe);
  end

  // Array write, gated so that mem_ctrl is ignored while reset is high.
  always_ff @(posedge clock) begin
    if (!reset && wr && !mar_oob) begin
      MainMemory[mar_idx] <= bus.mdr_out;
    end
  end

  // First pipeline stage, filled at the sampling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1 <= req;
    end
  end

  // A second stage exists only for the two-edge latency.
  generate
    if (MEM_LATENCY == 2) begin : g_two_stage
      stage_t s2;
      always_ff @(posedge clock) begin
        if (reset) begin
          s2 <= '0;
        end else begin
          s2 <= s1;
        end
      end
      assign last = s2;
    end else begin : g_one_stage
      assign last = s1;
    end
  endgenerate

  // Output registers. The data buses only move together with their strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mdr_in   <= '0;
      bus.mdr_load <= 1'b0;
      bus.mbr_in   <= '0;
      bus.mbr_load <= 1'b0;
      bus.fault    <= 1'b0;
    end else begin
      bus.mdr_load <= last.rd_v;
      bus.mbr_load <= last.fe_v;
      bus.fault    <= last.flt;
      if (last.rd_v) begin
        bus.mdr_in <= last.rd_data;
      end
      if (last.fe_v) begin
        bus.mbr_in <= last.fe_byte;
      end
    end
  end

endmodule

// File: tb/tb_mic1_mem_responder.sv
// tb_mic1_mem_responder -- drives one request stream into two responders,
// one with MEM_LATENCY=1 and one with MEM_LATENCY=2. Expected strobes are
// queued with the cycle in which they must appear. Negedge monitors pop the
// queues and compare each strobe against its entry.

module tb_mic1_mem_responder;

  localparam int AWD = 1024;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  mic1_mem_responder_if bus0();
  mic1_mem_responder_if bus1();

  assign bus1.mem_ctrl = bus0.mem_ctrl;
  assign bus1.mar      = bus0.mar;
  assign bus1.mdr_out  = bus0.mdr_out;
  assign bus1.pc       = bus0.pc;

  mic1_mem_responder #(.ADDR_WORDS(AWD), .MEM_LATENCY(1)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  mic1_mem_responder #(.ADDR_WORDS(AWD), .MEM_LATENCY(2)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [AWD];
  logic [63:0] mdr_q0[$];
  logic [63:0] mdr_q1[$];
  logic [63:0] mbr_q0[$];
  logic [63:0] mbr_q1[$];
  logic [31:0] flt_q0[$];
  logic [31:0] flt_q1[$];
  logic [31:0] last_mdr0 = 32'd0;
  logic [31:0] last_mdr1 = 32'd0;
  logic [7:0]  last_mbr0 = 8'd0;
  logic [7:0]  last_mbr1 = 8'd0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: strobe at cycle %0d with nothing expected", nm, cyc);
  endfunction

  // Monitor for the latency-1 responder.
  always @(negedge clock) begin
    logic [63:0] e;
    logic [31:0] f;
    if (bus0.mdr_load === 1'b1) begin
      if (mdr_q0.size() == 0) unexpected("mdr0");
      else begin
        e = mdr_q0.pop_front();
        chk("mdr0_cycle", 32'(cyc), e[63:32]);
        chk("mdr0_data", bus0.mdr_in, e[31:0]);
        last_mdr0 = e[31:0];
      end
    end else chk("mdr0_hold", bus0.mdr_in, last_mdr0);
    if (bus0.mbr_load === 1'b1) begin
      if (mbr_q0.size() == 0) unexpected("mbr0");
      else begin
        e = mbr_q0.pop_front();
        chk("mbr0_cycle", 32'(cyc), e[63:32]);
        chk("mbr0_data", {24'd0, bus0.mbr_in}, e[31:0]);
        last_mbr0 = e[7:0];
      end
    end else chk("mbr0_hold", {24'd0, bus0.mbr_in}, {24'd0, last_mbr0});
    if (bus0.fault === 1'b1) begin
      if (flt_q0.size() == 0) unexpected("fault0");
      else begin
        f = flt_q0.pop_front();
        chk("fault0_cycle", 32'(cyc), f);
      end
    end
    if (reset) begin
      last_mdr0 = 32'd0;
      last_mbr0 = 8'd0;
    end
  end

  // Monitor for the latency-2 responder.
  always @(negedge clock) begin
    logic [63:0] e;
    logic [31:0] f;
    if (bus1.mdr_load === 1'b1) begin
      if (mdr_q1.size() == 0) unexpected("mdr1");
      else begin
        e = mdr_q1.pop_front();
        chk("mdr1_cycle", 32'(cyc), e[63:32]);
        chk("mdr1_data", bus1.mdr_in, e[31:0]);
        last_mdr1 = e[31:0];
      end
    end else chk("mdr1_hold", bus1.mdr_in, last_mdr1);
    if (bus1.mbr_load === 1'b1) begin
      if (mbr_q1.size() == 0) unexpected("mbr1");
      else begin
        e = mbr_q1.pop_front();
        chk("mbr1_cycle", 32'(cyc), e[63:32]);
        chk("mbr1_data", {24'd0, bus1.mbr_in}, e[31:0]);
        last_mbr1 = e[7:0];
      end
    end else chk("mbr1_hold", {24'd0, bus1.mbr_in}, {24'd0, last_mbr1});
    if (bus1.fault === 1'b1) begin
      if (flt_q1.size() == 0) unexpected("fault1");
      else begin
        f = flt_q1.pop_front();
        chk("fault1_cycle", 32'(cyc), f);
      end
    end
    if (reset) begin
      last_mdr1 = 32'd0;
      last_mbr1 = 8'd0;
    end
  end

  // ---------------- driver tasks ----------------
  // Issues one request, computes the expected strobes from the reference
  // memory, and queues them. The request is sampled at edge cyc+1, so the
  // strobe is due at cyc+1+latency.
  task automatic issue(input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p);
    logic        mo;
    logic        po;
    logic        flt;
    logic [31:0] ia;
    logic [31:0] ip;
    logic [31:0] pw;
    logic [31:0] rw;
    logic [31:0] fw;
    logic [7:0]  fb;
    logic [31:0] n;
    ia  = a % 32'(AWD);
    pw  = p >> 2;
    ip  = pw % 32'(AWD);
    mo  = BOUNDS && (a >= 32'(AWD));
    po  = BOUNDS && (pw >= 32'(AWD));
    rw  = mo ? 32'd0 : model[ia[9:0]];
    fw  = po ? 32'd0 : model[ip[9:0]];
    fb  = 8'(fw >> (8 * (3 - int'(p[1:0]))));
    flt = (ctrl[2] && ctrl[1]) || (mo && (ctrl[2] || ctrl[1])) || (po && ctrl[0]);
    n   = 32'(cyc);
    if (ctrl[1] && !ctrl[2]) begin
      mdr_q0.push_back({n + 32'd2, rw});
      mdr_q1.push_back({n + 32'd3, rw});
    end
    if (ctrl[0]) begin
      mbr_q0.push_back({n + 32'd2, 24'd0, fb});
      mbr_q1.push_back({n + 32'd3, 24'd0, fb});
    end
    if (flt) begin
      flt_q0.push_back(n + 32'd2);
      flt_q1.push_back(n + 32'd3);
    end
    if (ctrl[2] && !mo) model[ia[9:0]] = d;
    bus0.mem_ctrl = ctrl;
    bus0.mar      = a;
    bus0.mdr_out  = d;
    bus0.pc       = p;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int k);
    bus0.mem_ctrl = 3'b000;
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mdr_in0"},   bus0.mdr_in, 32'd0);
    chk({tag, "_mdr_load0"}, {31'd0, bus0.mdr_load}, 32'd0);
    chk({tag, "_mbr_in0"},   {24'd0, bus0.mbr_in}, 32'd0);
    chk({tag, "_mbr_load0"}, {31'd0, bus0.mbr_load}, 32'd0);
    chk({tag, "_fault0"},    {31'd0, bus0.fault}, 32'd0);
    chk({tag, "_mdr_in1"},   bus1.mdr_in, 32'd0);
    chk({tag, "_mdr_load1"}, {31'd0, bus1.mdr_load}, 32'd0);
    chk({tag, "_mbr_in1"},   {24'd0, bus1.mbr_in}, 32'd0);
    chk({tag, "_mbr_load1"}, {31'd0, bus1.mbr_load}, 32'd0);
    chk({tag, "_fault1"},    {31'd0, bus1.fault}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus0.mem_ctrl = 3'b000;
    bus0.mar      = 32'd0;
    bus0.mdr_out  = 32'd0;
    bus0.pc       = 32'd0;
    reset         = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // Load the words used below.
    issue(3'b100, 32'd5, 32'h12345678, 32'd0);
    issue(3'b100, 32'd3, 32'h11111111, 32'd0);

    // Plain read of word 5.
    issue(3'b010, 32'd5, 32'd0, 32'd0);
    idle(3);

    // Fetch lanes 1 and 2 of word 5 on consecutive cycles: 0x34, then 0x56.
    issue(3'b001, 32'd0, 32'd0, 32'd21);
    issue(3'b001, 32'd0, 32'd0, 32'd22);
    idle(3);

    // Illegal write plus read to word 3, then a read that sees the write.
    issue(3'b110, 32'd3, 32'hDEADBEEF, 32'd0);
    issue(3'b010, 32'd3, 32'd0, 32'd0);
    idle(3);

    // Read and fetch in the same cycle: 0x12345678 and 0x12.
    issue(3'b011, 32'd5, 32'd0, 32'd20);
    idle(3);

    // A fetch in the same cycle as a write to its word returns old data.
    issue(3'b101, 32'd5, 32'hCAFEF00D, 32'd20);
    issue(3'b001, 32'd0, 32'd0, 32'd20);
    issue(3'b001, 32'd0, 32'd0, 32'd23);
    issue(3'b100, 32'd5, 32'h12345678, 32'd0);

    // Back-to-back reads mixed with fetches.
    issue(3'b010, 32'd3, 32'd0, 32'd0);
    issue(3'b011, 32'd5, 32'd0, 32'd13);
    issue(3'b010, 32'd3, 32'd0, 32'd0);
    idle(3);

    // Address at the top of the array: faults with bounds checking, and
    // wraps to word 5 without it.
    issue(3'b010, 32'(AWD + 5), 32'd0, 32'd0);
    issue(3'b001, 32'd0, 32'd0, 32'(AWD * 4 + 21));
    issue(3'b100, 32'(AWD + 5), 32'hFFFFFFFF, 32'd0);
    issue(3'b010, 32'd5, 32'd0, 32'd0);
    issue(3'b100, 32'd5, 32'h12345678, 32'd0);
    idle(4);

    // Reset one edge after a read is sampled. The request is discarded, and
    // a write that is presented during reset is ignored.
    bus0.mem_ctrl = 3'b010;
    bus0.mar      = 32'd5;
    @(posedge clock);
    #1;
    reset         = 1'b1;
    bus0.mem_ctrl = 3'b100;
    bus0.mar      = 32'd5;
    bus0.mdr_out  = 32'hBAD0BAD0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk_zero("midreset");
    reset = 1'b0;
    idle(3);
    issue(3'b010, 32'd5, 32'd0, 32'd0);
    issue(3'b001, 32'd0, 32'd0, 32'd20);
    idle(5);

    chk("mdr_q0_left", 32'(mdr_q0.size()), 32'd0);
    chk("mdr_q1_left", 32'(mdr_q1.size()), 32'd0);
    chk("mbr_q0_left", 32'(mbr_q0.size()), 32'd0);
    chk("mbr_q1_left", 32'(mbr_q1.size()), 32'd0);
    chk("flt_q0_left", 32'(flt_q0.size()), 32'd0);
    chk("flt_q1_left", 32'(flt_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mic1_mem_responder.md
MIC1_MEM_RESPONDER -- requirements
Module: mic1_mem_responder

Interface
REQ-001 SHALL provide parameter ADDR_WORDS, default 1024, depth of the internal 32-bit word array (power of two).
REQ-002 SHALL provide parameter MEM_LATENCY, default 1, edges from request sample to data strobe (legal values 1 or 2).
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_ctrl  in  3  {write, read, fetch} bits taken from the MEM field of the microinstruction.
REQ-006 mar  in  32  word address for read and write.
REQ-007 mdr_out  in  32  write data, from the MDR register.
REQ-008 pc  in  32  byte address for fetch.
REQ-009 mdr_in  out  32  read data to MDR.
REQ-010 mdr_load  out  1  one-cycle strobe; MDR captures mdr_in.
REQ-011 mbr_in  out  8  fetched byte to MBR.
REQ-012 mbr_load  out  1  one-cycle strobe; MBR captures mbr_in.
REQ-013 fault  out  1  one-cycle pulse on an illegal request.

Function
REQ-014 SHALL sample mem_ctrl, mar, mdr_out and pc on every rising edge with reset low.
REQ-015 Write: SHALL commit mdr_out to word (mar mod ADDR_WORDS) at the sampling edge; no strobe is produced.
REQ-016 Read: SHALL drive mdr_in with the addressed word and assert mdr_load for exactly one cycle, beginning MEM_LATENCY edges after the sampling edge.
REQ-017 Fetch: word = (pc>>2) mod ADDR_WORDS; byte lane pc[1:0]; lane 0 = bits[31:24], lane 3 = bits[7:0] (big-endian). The byte SHALL be returned on mbr_in with mbr_load, using the same latency as a read.
REQ-018 Read and fetch SHALL be independent pipelines; both may be issued in the same cycle and SHALL strobe in the same cycle.
REQ-019 SHALL accept a new request on every cycle (fully pipelined); each request produces exactly one strobe, in issue order.
REQ-020 Read or fetch data SHALL reflect every write sampled on an earlier edge. A same-edge write to the same word SHALL NOT be visible (old data is returned).
REQ-021 Write with read in the same cycle is illegal: the write SHALL be performed, the read dropped (no mdr_load), and fault pulsed MEM_LATENCY edges later.
REQ-022 mdr_in and mbr_in SHALL hold their last value while their strobe is low.
REQ-023 With MEM_LATENCY=2, a two-stage request pipeline (valid bit, address, lane) SHALL be used. With MEM_LATENCY=1, a single stage SHALL be used.

Reset
REQ-024 On reset: mdr_in=0, mbr_in=0, mdr_load=0, mbr_load=0, fault=0; all in-flight pipeline valid bits are cleared.
REQ-025 Requests in flight at reset SHALL be discarded; no strobe SHALL appear afterwards for them.
REQ-026 The memory array SHALL NOT be cleared by reset; contents are preloaded externally via the hierarchical name MainMemory.
REQ-027 mem_ctrl SHALL be ignored while reset is high; no write occurs.

Configuration
REQ-028 Macro MEM_BOUNDS_CHECK_EN defined:
- a read, write or fetch whose word address is at or above ADDR_WORDS SHALL be suppressed (no write; returned data 0);
- its strobe SHALL still occur;
- fault SHALL pulse with the strobe timing.
REQ-029 Macro MEM_BOUNDS_CHECK_EN undefined: addresses SHALL wrap modulo ADDR_WORDS and fault SHALL pulse only per REQ-021.

Verification
REQ-030 Preload word 5=0x12345678; mem_ctrl=010, mar=5 -> mdr_in=0x12345678 with mdr_load high, MEM_LATENCY edges later, for one cycle.
REQ-031 Same preload; fetch with pc=21, then pc=22 on consecutive cycles -> mbr_in=0x34, then 0x56, on consecutive strobes.
REQ-032 Write 0xDEADBEEF to mar=3 while reading mar=3 in the same cycle, then read mar=3 in the next cycle -> first read dropped with fault=1; second read returns 0xDEADBEEF.
REQ-033 Read mar=5 and fetch pc=20 in the same cycle -> mdr_load and mbr_load in the same cycle; mdr_in=0x12345678, mbr_in=0x12.
REQ-034 Issue a read, then assert reset on the next edge (MEM_LATENCY=2) -> no mdr_load; all outputs 0.
REQ-035 Read mar=ADDR_WORDS+5 -> with MEM_BOUNDS_CHECK_EN: mdr_in=0, fault=1; without it: mdr_in=0x12345678, fault=0.
